// File: rtl/lb_fabric.sv
// Local-bus fabric: decodes host strobes into a local register window and
// NUM_CH downstream channel windows. Channel reads are tracked by a two-state
// FSM with a timeout that returns a marker word and records the event.
module lb_fabric #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ID_VALUE    = 32'h12345678
) (
    input  logic                   clk_lb,
    input  logic                   reset_n,
    input  logic                   lb_wr,
    input  logic                   lb_rd,
    input  logic [31:0]            lb_addr,
    input  logic [31:0]            lb_wr_d,
    output logic [31:0]            lb_rd_d,
    output logic                   lb_rd_rdy,
    output logic [NUM_CH-1:0]      ch_wr,
    output logic [NUM_CH-1:0]      ch_rd,
    output logic [15:0]            ch_addr,
    output logic [31:0]            ch_wr_d,
    input  logic [NUM_CH*32-1:0]   ch_rd_d,
    input  logic [NUM_CH-1:0]      ch_rd_rdy,
    output logic                   err
);

    typedef enum logic {IDLE, WAIT_CH} state_t;

    state_t              state_q, state_d;
    logic [31:0]         rdat_q, rdat_d;
    logic                rrdy_q, rrdy_d;
    logic [NUM_CH-1:0]   chwr_q, chwr_d;
    logic [NUM_CH-1:0]   chrd_q, chrd_d;
    logic [15:0]         chaddr_q, chaddr_d;
    logic [31:0]         chdat_q, chdat_d;
    logic [31:0]         scratch_q, scratch_d;
    logic [15:0]         tocnt_q, tocnt_d;
    logic [7:0]          drop_q, drop_d;
    logic [2:0]          last_q, last_d;
    logic                err_q, err_d;
    logic [2:0]          sel_q, sel_d;
    logic [15:0]         timer_q, timer_d;

    // Address decode
    logic [3:0]          win;
    logic [15:0]         off;
    logic                is_local, is_ch;
    logic [2:0]          win_k;
    logic [NUM_CH-1:0]   win_oh;
    logic                rsp_rdy;
    logic [31:0]         rsp_data;
    logic [31:0]         status;
    logic [31:0]         local_rdata;
    logic                clear, tmo_hit;
    logic [1:0]          ndrop;
    logic [8:0]          drop_sum;
    logic                unused_addr;

    assign win         = lb_addr[19:16];
    assign off         = lb_addr[15:0];
    assign unused_addr = ^lb_addr[31:20];
    assign is_local    = (win == 4'd0);
    assign is_ch       = (win != 4'd0) && (32'(win) <= NUM_CH);
    assign win_k       = 3'(win - 4'd1);
    assign status      = {err_q, 4'd0, last_q, drop_q, tocnt_q};

    // Channel one-hot for the decoded window and response mux for the latched channel
    always_comb begin
        win_oh   = '0;
        rsp_rdy  = 1'b0;
        rsp_data = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (win_k == 3'(i)) win_oh[i] = 1'b1;
            if (sel_q == 3'(i)) begin
                rsp_rdy  = ch_rd_rdy[i];
                rsp_data = ch_rd_d[i*32 +: 32];
            end
        end
    end

    // Local register read mux; CLEAR and undefined offsets read as zero
    always_comb begin
        local_rdata = '0;
        case (off)
            16'h0000: local_rdata = ID_VALUE;
            16'h0004: local_rdata = scratch_q;
            16'h0008: local_rdata = status;
            default:  local_rdata = '0;
        endcase
    end

    // Next-state and output logic; strobes are accepted only in IDLE
    always_comb begin
        state_d   = state_q;
        rdat_d    = '0;
        rrdy_d    = 1'b0;
        chwr_d    = '0;
        chrd_d    = '0;
        chaddr_d  = chaddr_q;
        chdat_d   = chdat_q;
        scratch_d = scratch_q;
        tocnt_d   = tocnt_q;
        drop_d    = drop_q;
        last_d    = last_q;
        err_d     = err_q;
        sel_d     = sel_q;
        timer_d   = timer_q;
        clear     = 1'b0;
        tmo_hit   = 1'b0;
        ndrop     = 2'd0;
        drop_sum  = '0;

        case (state_q)
            IDLE: begin
                if (lb_wr) begin
                    // A write wins over a simultaneous read; the read is dropped
                    if (is_local) begin
                        if (off == 16'h0004)      scratch_d = lb_wr_d;
                        else if (off == 16'h000C) clear     = 1'b1;
                    end else if (is_ch) begin
                        chwr_d   = win_oh;
                        chaddr_d = off;
                        chdat_d  = lb_wr_d;
                    end
                    if (lb_rd) ndrop = 2'd1;
                end else if (lb_rd) begin
                    if (is_ch) begin
                        chrd_d   = win_oh;
                        chaddr_d = off;
                        sel_d    = win_k;
                        timer_d  = 16'(TIMEOUT_CYC);
                        state_d  = WAIT_CH;
                    end else begin
                        rrdy_d = 1'b1;
                        rdat_d = is_local ? local_rdata : 32'd0;
                    end
                end
            end
            WAIT_CH: begin
                ndrop   = {1'b0, lb_wr} + {1'b0, lb_rd};
                timer_d = timer_q - 16'd1;
                // A response in the final counted cycle still beats the timeout
                if (rsp_rdy) begin
                    rrdy_d  = 1'b1;
                    rdat_d  = rsp_data;
                    state_d = IDLE;
                end else if (timer_q == 16'd1) begin
                    tmo_hit = 1'b1;
                    rrdy_d  = 1'b1;
                    rdat_d  = 32'hDEAD0000 | {29'd0, sel_q};
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear applies first so that a coincident event lands on zeroed counters
        if (clear) begin
            tocnt_d = '0;
            drop_d  = '0;
            last_d  = '0;
            err_d   = 1'b0;
        end
        if (tmo_hit) begin
            tocnt_d = (tocnt_d == 16'hFFFF) ? tocnt_d : tocnt_d + 16'd1;
            last_d  = sel_q;
            err_d   = 1'b1;
        end
        drop_sum = {1'b0, drop_d} + {7'd0, ndrop};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // State and output registers
    always_ff @(posedge clk_lb or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rdat_q    <= '0;
            rrdy_q    <= 1'b0;
            chwr_q    <= '0;
            chrd_q    <= '0;
            chaddr_q  <= '0;
            chdat_q   <= '0;
            scratch_q <= '0;
            tocnt_q   <= '0;
            drop_q    <= '0;
            last_q    <= '0;
            err_q     <= 1'b0;
            sel_q     <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            rdat_q    <= rdat_d;
            rrdy_q    <= rrdy_d;
            chwr_q    <= chwr_d;
            chrd_q    <= chrd_d;
            chaddr_q  <= chaddr_d;
            chdat_q   <= chdat_d;
            scratch_q <= scratch_d;
            tocnt_q   <= tocnt_d;
            drop_q    <= drop_d;
            last_q    <= last_d;
            err_q     <= err_d;
            sel_q     <= sel_d;
            timer_q   <= timer_d;
        end
    end

    assign lb_rd_d   = rdat_q;
    assign lb_rd_rdy = rrdy_q;
    assign ch_wr     = chwr_q;
    assign ch_rd     = chrd_q;
    assign ch_addr   = chaddr_q;
    assign ch_wr_d   = chdat_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lb_fabric.sv
// Scoreboard bench for lb_fabric: stimulus pushes expected read responses and
// channel strobes into queues, monitors pop and compare on every DUT output.
module tb_lb_fabric;

    localparam int NCH = 2;
    localparam int TMO = 6;
    localparam logic [31:0] IDV = 32'h12345678;

    logic              clk_lb = 1'b0;
    logic              reset_n = 1'b0;
    logic              lb_wr = 1'b0;
    logic              lb_rd = 1'b0;
    logic [31:0]       lb_addr = '0;
    logic [31:0]       lb_wr_d = '0;
    logic [31:0]       lb_rd_d;
    logic              lb_rd_rdy;
    logic [NCH-1:0]    ch_wr;
    logic [NCH-1:0]    ch_rd;
    logic [15:0]       ch_addr;
    logic [31:0]       ch_wr_d;
    logic [NCH*32-1:0] ch_rd_d = '0;
    logic [NCH-1:0]    ch_rd_rdy = '0;
    logic              err;

    lb_fabric #(.NUM_CH(NCH), .TIMEOUT_CYC(TMO), .ID_VALUE(IDV)) dut (
        .clk_lb(clk_lb), .reset_n(reset_n), .lb_wr(lb_wr), .lb_rd(lb_rd),
        .lb_addr(lb_addr), .lb_wr_d(lb_wr_d), .lb_rd_d(lb_rd_d),
        .lb_rd_rdy(lb_rd_rdy), .ch_wr(ch_wr), .ch_rd(ch_rd), .ch_addr(ch_addr),
        .ch_wr_d(ch_wr_d), .ch_rd_d(ch_rd_d), .ch_rd_rdy(ch_rd_rdy), .err(err)
    );

    always #5 clk_lb = ~clk_lb;

    typedef struct {
        bit          is_wr;
        int          ch;
        logic [15:0] addr;
        logic [31:0] data;
    } ch_ev_t;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_rd_q[$];
    ch_ev_t      exp_ch_q[$];

    // Reference model state
    logic [31:0] m_scratch = '0;
    int          m_tocnt = 0;
    int          m_drop = 0;
    int          m_last = 0;
    int          m_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] m_status();
        return 32'(m_tocnt) + (32'(m_drop) << 16) + (32'(m_last) << 24) + (32'(m_err) << 31);
    endfunction

    function automatic logic [31:0] m_local(input logic [15:0] off);
        if (off == 16'h0) return IDV;
        if (off == 16'h4) return m_scratch;
        if (off == 16'h8) return m_status();
        return 32'd0;
    endfunction

    function automatic logic [31:0] mk_addr(input int w, input logic [15:0] off);
        return (32'(w) << 16) | 32'(off);
    endfunction

    function automatic void m_clear();
        m_tocnt = 0; m_drop = 0; m_last = 0; m_err = 0;
    endfunction

    function automatic void m_drop_inc();
        if (m_drop < 255) m_drop++;
    endfunction

    // Read-response monitor
    always @(negedge clk_lb) begin
        if (reset_n) begin
            if (lb_rd_rdy) begin
                if (exp_rd_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_rdy: got lb_rd_d=%h with no read outstanding", lb_rd_d);
                end else begin
                    check("rd_data", lb_rd_d, exp_rd_q.pop_front());
                end
            end else begin
                check("rd_d_idle", lb_rd_d, 32'd0);
            end
        end
    end

    // Channel strobe monitor
    always @(negedge clk_lb) begin
        if (reset_n && ((ch_wr | ch_rd) != '0)) begin
            if (exp_ch_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_ch: got ch_wr=%b ch_rd=%b expected none", ch_wr, ch_rd);
            end else begin
                ch_ev_t ev;
                ev = exp_ch_q.pop_front();
                check("ch_wr", 32'(ch_wr), ev.is_wr ? (32'd1 << ev.ch) : 32'd0);
                check("ch_rd", 32'(ch_rd), ev.is_wr ? 32'd0 : (32'd1 << ev.ch));
                check("ch_addr", 32'(ch_addr), 32'(ev.addr));
                if (ev.is_wr) check("ch_wr_d", ch_wr_d, ev.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk_lb); #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_rd_q.size() != 0 || exp_ch_q.size() != 0) && n < 40) begin
            tick(); n++;
        end
        if (exp_rd_q.size() != 0 || exp_ch_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d reads and %0d strobes pending, expected 0", exp_rd_q.size(), exp_ch_q.size());
            exp_rd_q.delete(); exp_ch_q.delete();
        end
        tick();
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic host_rd(input logic [31:0] a);
        lb_addr = a; lb_rd = 1'b1; tick(); lb_rd = 1'b0;
    endtask

    task automatic host_wr(input logic [31:0] a, input logic [31:0] d);
        lb_addr = a; lb_wr_d = d; lb_wr = 1'b1; tick(); lb_wr = 1'b0;
    endtask

    // Local or unmapped read: response one cycle after the strobe
    task automatic op_rd_1cyc(input int w, input logic [15:0] off);
        exp_rd_q.push_back(w == 0 ? m_local(off) : 32'd0);
        host_rd(mk_addr(w, off));
        @(negedge clk_lb);
        check("rd_latency", 32'(lb_rd_rdy), 32'd1);
        drain();
    endtask

    task automatic op_local_wr(input logic [15:0] off, input logic [31:0] d);
        host_wr(mk_addr(0, off), d);
        if (off == 16'h4) m_scratch = d;
        if (off == 16'hC) m_clear();
        drain();
    endtask

    task automatic op_ch_wr(input int k, input logic [15:0] off, input logic [31:0] d);
        exp_ch_q.push_back('{1'b1, k, off, d});
        host_wr(mk_addr(k + 1, off), d);
        drain();
    endtask

    task automatic op_unmapped_wr(input int w, input logic [15:0] off, input logic [31:0] d);
        host_wr(mk_addr(w, off), d);
        drain();
    endtask

    // Simultaneous write and read in IDLE: write lands, read dropped
    task automatic op_both(input bit to_ch, input int k, input logic [15:0] off, input logic [31:0] d);
        if (to_ch) exp_ch_q.push_back('{1'b1, k, off, d});
        else m_scratch = d;
        m_drop_inc();
        lb_addr = to_ch ? mk_addr(k + 1, off) : 32'h4;
        lb_wr_d = d; lb_wr = 1'b1; lb_rd = 1'b1;
        tick();
        lb_wr = 1'b0; lb_rd = 1'b0;
        drain();
    endtask

    // Channel read; responder answers d cycles after the ch_rd cycle (d=0 same cycle).
    // The channel is allowed TMO cycles, so d<=TMO-1 answers and anything later times out.
    task automatic op_ch_rd(input int k, input logic [15:0] off, input int d,
                            input logic [31:0] data, input int drop_kind);
        exp_ch_q.push_back('{1'b0, k, off, 32'd0});
        if (d < TMO) begin
            exp_rd_q.push_back(data);
        end else begin
            exp_rd_q.push_back(32'hDEAD0000 | 32'(k));
            if (m_tocnt < 65535) m_tocnt++;
            m_last = k; m_err = 1;
        end
        if (drop_kind != 0) m_drop_inc();
        host_rd(mk_addr(k + 1, off));
        for (int c = 0; c <= TMO + 1; c++) begin
            if (c == d) begin
                ch_rd_rdy[k] = 1'b1;
                ch_rd_d[k*32 +: 32] = data;
            end
            if (c == 0) begin
                ch_rd_rdy[1-k] = 1'b1;
                ch_rd_d[(1-k)*32 +: 32] = 32'hBAD00000;
                if (drop_kind == 1) begin
                    lb_addr = mk_addr($urandom_range(0, 2), 16'h4);
                    lb_wr_d = $urandom; lb_wr = 1'b1;
                end
                if (drop_kind == 2) lb_rd = 1'b1;
            end
            tick();
            ch_rd_rdy = '0; ch_rd_d = '0; lb_wr = 1'b0; lb_rd = 1'b0;
        end
        drain();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_d"}, lb_rd_d, 32'd0);
        check({tag, "_rd_rdy"}, 32'(lb_rd_rdy), 32'd0);
        check({tag, "_ch_wr"}, 32'(ch_wr), 32'd0);
        check({tag, "_ch_rd"}, 32'(ch_rd), 32'd0);
        check({tag, "_ch_addr"}, 32'(ch_addr), 32'd0);
        check({tag, "_ch_wr_d"}, ch_wr_d, 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // ID, scratch write/readback
        op_rd_1cyc(0, 16'h0);
        op_local_wr(16'h4, 32'hA5A5F00F);
        op_rd_1cyc(0, 16'h4);

        // Channel 1 answers after 5 cycles, last allowed cycle
        op_ch_rd(1, 16'h0010, 5, 32'hCAFE0001, 0);
        op_rd_1cyc(0, 16'h8);

        // Channel 0 silent -> timeout marker, STATUS 0x80000001
        op_ch_rd(0, 16'h0000, 99, 32'h0, 0);
        op_rd_1cyc(0, 16'h8);

        // Drops: write during WAIT_CH, then write+read together in IDLE
        op_ch_rd(0, 16'h0020, 2, 32'h13572468, 1);
        op_both(1'b0, 0, 16'h4, 32'h11223344);
        op_rd_1cyc(0, 16'h8);
        op_rd_1cyc(0, 16'h4);
        op_local_wr(16'hC, 32'h0);
        op_rd_1cyc(0, 16'h8);

        // Unmapped window and ignored writes
        op_rd_1cyc(3, 16'h0000);
        op_unmapped_wr(5, 16'h0004, 32'hFFFFFFFF);
        op_local_wr(16'h0, 32'h0BADBEEF);
        op_rd_1cyc(0, 16'h0);
        op_ch_wr(0, 16'h1234, 32'hDEADBEEF);
        op_ch_wr(1, 16'hFFFC, 32'h00000001);

        // Randomized mix
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 6))
                0: op_rd_1cyc(0, 16'(4 * $urandom_range(0, 4)));
                1: op_local_wr(16'(4 * $urandom_range(0, 3)), $urandom);
                2: op_ch_wr($urandom_range(0, NCH - 1), 16'($urandom), $urandom);
                3: op_ch_rd($urandom_range(0, NCH - 1), 16'($urandom), $urandom_range(0, TMO + 1),
                            $urandom, $urandom_range(0, 2));
                4: op_rd_1cyc($urandom_range(NCH + 1, 15), 16'($urandom));
                5: op_unmapped_wr($urandom_range(NCH + 1, 15), 16'($urandom), $urandom);
                default: op_both($urandom_range(0, 1) == 1, $urandom_range(0, NCH - 1),
                                 16'($urandom), $urandom);
            endcase
        end
        op_rd_1cyc(0, 16'h8);

        // Reset in the middle of WAIT_CH abandons the read
        exp_ch_q.push_back('{1'b0, 0, 16'h0040, 32'd0});
        host_rd(mk_addr(1, 16'h0040));
        tick(); tick();
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        m_scratch = '0; m_clear();
        tick();
        reset_n = 1'b1;
        ch_rd_rdy[0] = 1'b1; ch_rd_d[31:0] = 32'h55AA55AA;
        tick();
        ch_rd_rdy = '0; ch_rd_d = '0;
        repeat (TMO + 2) tick();
        drain();
        op_rd_1cyc(0, 16'h8);
        op_rd_1cyc(0, 16'h4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lb_fabric.md
LB_FABRIC -- requirements
Module: lb_fabric

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of downstream local-bus channels (legal range 1..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 255, giving the number of clk_lb cycles to wait for a channel read response (legal range 2..65535).
REQ-003 The block SHALL have parameter ID_VALUE, default 32'h12345678, giving the constant returned by the ID register.
REQ-004 Port clk_lb, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port lb_wr, input, 1 bit: single-cycle write strobe from the host.
REQ-007 Port lb_rd, input, 1 bit: single-cycle read strobe from the host.
REQ-008 Port lb_addr, input, 32 bits: byte address, with bits [19:16] selecting the window and bits [15:0] the offset.
REQ-009 Port lb_wr_d, input, 32 bits: write data.
REQ-010 Port lb_rd_d, output, 32 bits: read data, valid only while lb_rd_rdy is 1 and 0 otherwise.
REQ-011 Port lb_rd_rdy, output, 1 bit: single-cycle read-response strobe.
REQ-012 Port ch_wr / ch_rd, output, NUM_CH bits each: per-channel one-cycle write and read strobes.
REQ-013 Port ch_addr, output, 16 bits: shared registered offset, equal to lb_addr[15:0].
REQ-014 Port ch_wr_d, output, 32 bits: shared registered write data.
REQ-015 Port ch_rd_d, input, NUM_CH*32 bits: per-channel read data, with channel k in bits [32k+31:32k].
REQ-016 Port ch_rd_rdy, input, NUM_CH bits: per-channel read-response strobes.
REQ-017 Port err, output, 1 bit: sticky flag, set when any channel read times out.

Function
REQ-018 Window 0 SHALL be local: offset 0x0 is ID (RO, ID_VALUE), 0x4 is SCRATCH (RW, 32 bits), 0x8 is STATUS (RO: [15:0] timeout_cnt, [23:16] drop_cnt, [26:24] last timed-out channel, [31] err), and 0xC is CLEAR (WO: any write zeroes timeout_cnt, drop_cnt, last channel and err).
REQ-019 Window k+1, for k < NUM_CH, SHALL map to channel k; windows above NUM_CH SHALL be unmapped.
REQ-020 FSM states SHALL be IDLE and WAIT_CH; only IDLE accepts strobes.
REQ-021 In IDLE, a write to channel k SHALL assert ch_wr[k] for exactly one cycle, one cycle after lb_wr, with ch_addr and ch_wr_d registered in the same cycle; the state remains IDLE.
REQ-022 In IDLE, a local or unmapped read SHALL assert lb_rd_rdy exactly one cycle after lb_rd, and an unmapped read SHALL return 0.
REQ-023 Unmapped writes, and writes to local offsets other than 0x4 and 0xC, SHALL be ignored.
REQ-024 In IDLE, a read to channel k SHALL pulse ch_rd[k] one cycle after lb_rd, latch k, load a timeout counter with TIMEOUT_CYC, and enter WAIT_CH.
REQ-025 In WAIT_CH, ch_rd_rdy[k] of the latched channel SHALL produce lb_rd_rdy=1 with lb_rd_d=ch_rd_d[k] on the next cycle, then return to IDLE; ch_rd_rdy from other channels SHALL be ignored.
REQ-026 In WAIT_CH, the timeout counter SHALL decrement each cycle; on reaching 0 without a response, the block SHALL emit lb_rd_rdy with lb_rd_d = 32'hDEAD0000 | k, increment timeout_cnt (saturating at 16'hFFFF), record k, set err, and return to IDLE.
REQ-027 A response arriving in the same cycle the counter reaches 0 SHALL win, with no timeout recorded.
REQ-028 Any lb_wr or lb_rd seen in WAIT_CH SHALL be dropped and SHALL increment drop_cnt (saturating at 8'hFF).
REQ-029 When lb_wr and lb_rd are asserted in the same cycle in IDLE, the write SHALL execute, the read SHALL be dropped, and drop_cnt SHALL increment.
REQ-030 A CLEAR write and a simultaneous timeout SHALL leave the counters cleared and then apply the new timeout, giving timeout_cnt=1 and err=1.
REQ-031 At most one lb_rd_rdy SHALL be emitted per accepted read, and none for a dropped read.

Reset
REQ-032 While reset_n=0, the block SHALL drive lb_rd_d=0, lb_rd_rdy=0, ch_wr=0, ch_rd=0, ch_addr=0, ch_wr_d=0, err=0, clear SCRATCH and all counters to 0, and hold the FSM in IDLE.
REQ-033 Reset asserted during WAIT_CH SHALL abandon the read with no lb_rd_rdy, and any late ch_rd_rdy after release SHALL be ignored.

Verification
REQ-034 Read 0x0000 -> lb_rd_rdy one cycle later with lb_rd_d=32'h12345678; write 0x0004=32'hA5A5F00F, then read 0x0004 -> 32'hA5A5F00F.
REQ-035 NUM_CH=2: read 0x20010, channel 1 responds with 32'hCAFE0001 after 5 cycles -> ch_rd=2'b10 for one cycle, lb_rd_d=32'hCAFE0001, and no err.
REQ-036 TIMEOUT_CYC=4, read channel 0 with no response -> lb_rd_d=32'hDEAD0000 after the timeout, STATUS reads 32'h80000001, and err=1.
REQ-037 Strobe lb_wr during WAIT_CH, then simultaneous lb_wr and lb_rd in IDLE -> drop_cnt=2 and the write lands; a CLEAR write then gives STATUS=0.
REQ-038 Read 0x30000 with NUM_CH=2 -> returns 0 after one cycle; assert reset_n=0 mid-WAIT_CH -> no rdy, all outputs 0.
